// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the fetch queue and its storage sub-module.
package fetch_pkg;

    localparam int PC_INC = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fetch_q_fifo.sv
// Storage ring for the fetch queue: DEPTH entries of W bits with wrapping pointers.
// Only pointers and occupancy are reset; entry data is left unreset.
module fetch_q_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_q.sv
// Instruction fetch queue: credit-limited request issue, in-order response capture, flush with drop.
// Optional FETCH_Q_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_q
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_req_val,
    input  logic            i_req_rdy,
    output logic [XLEN-1:0] o_req_pc,
    input  logic            i_rsp_val,
    input  logic [XLEN-1:0] i_rsp_in,
    output logic            o_out_val,
    input  logic            i_out_rdy,
    output logic [XLEN-1:0] o_out_in,
    output logic [XLEN-1:0] o_out_pc,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc
);

    localparam int              CW  = clog2(DEPTH) + 1;
    localparam int              DW  = CW + 2;
    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   rsp_pc;
    logic [CW-1:0]     outst;
    logic [CW-1:0]     count;
    logic [DW-1:0]     drop;
    logic [2*XLEN-1:0] q_data;
    logic              req_fire;
    logic              out_fire;
    logic              rsp_acc;
    logic              byp;
    logic              push;
    logic              pop;

    // Credits cover both queued entries and responses still in flight.
    assign rsp_acc   = i_rsp_val & (drop == '0);
    assign o_req_val = !rst & !i_flush &
                       (({1'b0, count} + {1'b0, outst}) < (CW+1)'(DEPTH));
    assign o_req_pc  = fetch_pc;
    assign req_fire  = o_req_val & i_req_rdy;
    assign out_fire  = o_out_val & i_out_rdy;

`ifdef FETCH_Q_BYPASS_EN
    assign byp = !rst & (count == '0) & rsp_acc & !i_flush;
`else
    assign byp = 1'b0;
`endif

    assign o_out_val = !rst & ((count != '0) | byp);
    assign o_out_in  = byp ? i_rsp_in : q_data[2*XLEN-1:XLEN];
    assign o_out_pc  = byp ? rsp_pc   : q_data[XLEN-1:0];

    // A bypassed response consumed this cycle never enters storage.
    assign push = rsp_acc & !i_flush & !(byp & i_out_rdy);
    assign pop  = out_fire & (count != '0) & !i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
        end else if (i_flush) begin
            fetch_pc <= i_flush_pc;
            rsp_pc   <= i_flush_pc;
            outst    <= '0;
            // Any response arriving now is consumed, whether it was an accept or already a drop.
            drop     <= drop + DW'(outst) - DW'(i_rsp_val);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + INC;
            if (rsp_acc)  rsp_pc   <= rsp_pc + INC;
            case ({req_fire, rsp_acc})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
            if (i_rsp_val && (drop != '0)) drop <= drop - DW'(1);
        end
    end

    fetch_q_fifo #(
        .DEPTH (DEPTH),
        .W     (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_flush),
        .push  (push),
        .pop   (pop),
        .wdata ({i_rsp_in, rsp_pc}),
        .rdata (q_data),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_q.sv
// Directed table-driven bench for fetch_q (DEPTH=4, RESET_PC=0x100); tracks FETCH_Q_BYPASS_EN.
module tb_fetch_q;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_Q_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct packed {
        logic        rst;
        logic        req_rdy;
        logic        rsp_val;
        logic [31:0] rsp_in;
        logic        out_rdy;
        logic        flush;
        logic [31:0] flush_pc;
        logic        e_req_val;
        logic [31:0] e_req_pc;
        logic        e_out_val;
        logic [31:0] e_out_in;
        logic [31:0] e_out_pc;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_rdy = 1'b0;
    logic            rsp_val = 1'b0;
    logic [XLEN-1:0] rsp_in = '0;
    logic            out_rdy = 1'b0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] flush_pc = '0;
    logic            o_req_val;
    logic [XLEN-1:0] o_req_pc;
    logic            o_out_val;
    logic [XLEN-1:0] o_out_in;
    logic [XLEN-1:0] o_out_pc;

    int passed = 0;
    int total  = 0;
    int vec_id = 0;

    vec_t tbl_a[$];
    vec_t tbl_c[$];

    fetch_q #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .o_req_val  (o_req_val),
        .i_req_rdy  (req_rdy),
        .o_req_pc   (o_req_pc),
        .i_rsp_val  (rsp_val),
        .i_rsp_in   (rsp_in),
        .o_out_val  (o_out_val),
        .i_out_rdy  (out_rdy),
        .o_out_in   (o_out_in),
        .o_out_pc   (o_out_pc),
        .i_flush    (flush),
        .i_flush_pc (flush_pc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int rr, input int rv, input logic [31:0] rin,
                                input int ordy, input int fl, input logic [31:0] fpc,
                                input int erv, input logic [31:0] epc,
                                input int eov, input logic [31:0] ein, input logic [31:0] eopc);
        vec_t v;
        v.rst       = (r != 0);
        v.req_rdy   = (rr != 0);
        v.rsp_val   = (rv != 0);
        v.rsp_in    = rin;
        v.out_rdy   = (ordy != 0);
        v.flush     = (fl != 0);
        v.flush_pc  = fpc;
        v.e_req_val = (erv != 0);
        v.e_req_pc  = epc;
        v.e_out_val = (eov != 0);
        v.e_out_in  = ein;
        v.e_out_pc  = eopc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (vec %0d): got %h, expected %h", nm, vec_id, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        req_rdy  = v.req_rdy;
        rsp_val  = v.rsp_val;
        rsp_in   = v.rsp_in;
        out_rdy  = v.out_rdy;
        flush    = v.flush;
        flush_pc = v.flush_pc;
        #1;
        check("req_val", 32'(o_req_val), 32'(v.e_req_val));
        if (v.e_req_val) check("req_pc", o_req_pc, v.e_req_pc);
        check("out_val", 32'(o_out_val), 32'(v.e_out_val));
        if (v.e_out_val) begin
            check("out_in", o_out_in, v.e_out_in);
            check("out_pc", o_out_pc, v.e_out_pc);
        end
        vec_id++;
    endtask

    initial begin
        logic [31:0] prev;

        // Reset, fill four requests, four responses with decode stalled, then drain in order.
        tbl_a.push_back(mk(1,1,0,0,      0,0,0, 0,0,       0,0,0));
        tbl_a.push_back(mk(1,1,0,0,      0,0,0, 0,0,       0,0,0));
        tbl_a.push_back(mk(0,1,0,0,      0,0,0, 1,'h100,   0,0,0));
        tbl_a.push_back(mk(0,1,0,0,      0,0,0, 1,'h104,   0,0,0));
        tbl_a.push_back(mk(0,1,0,0,      0,0,0, 1,'h108,   0,0,0));
        tbl_a.push_back(mk(0,1,0,0,      0,0,0, 1,'h10C,   0,0,0));
        tbl_a.push_back(mk(0,1,0,0,      0,0,0, 0,0,       0,0,0));
        tbl_a.push_back(mk(0,0,1,'hA0,   0,0,0, 0,0,       BYP,'hA0,'h100));
        tbl_a.push_back(mk(0,0,1,'hA1,   0,0,0, 0,0,       1,'hA0,'h100));
        tbl_a.push_back(mk(0,0,1,'hA2,   0,0,0, 0,0,       1,'hA0,'h100));
        tbl_a.push_back(mk(0,0,1,'hA3,   0,0,0, 0,0,       1,'hA0,'h100));
        tbl_a.push_back(mk(0,1,0,0,      0,0,0, 0,0,       1,'hA0,'h100));
        tbl_a.push_back(mk(0,0,0,0,      1,0,0, 0,0,       1,'hA0,'h100));
        tbl_a.push_back(mk(0,0,0,0,      1,0,0, 1,'h110,   1,'hA1,'h104));
        tbl_a.push_back(mk(0,0,0,0,      1,0,0, 1,'h110,   1,'hA2,'h108));
        tbl_a.push_back(mk(0,0,0,0,      1,0,0, 1,'h110,   1,'hA3,'h10C));
        tbl_a.push_back(mk(0,0,0,0,      0,0,0, 1,'h110,   0,0,0));

        // Flush with three outstanding, flush coincident with response, bypass/latency, mid-run reset.
        tbl_c.push_back(mk(0,1,0,0,      0,0,0,      1,'h168, 0,0,0));
        tbl_c.push_back(mk(0,1,0,0,      0,0,0,      1,'h16C, 0,0,0));
        tbl_c.push_back(mk(0,1,0,0,      0,1,'h200,  0,0,     0,0,0));
        tbl_c.push_back(mk(0,1,1,'hE0,   0,0,0,      1,'h200, 0,0,0));
        tbl_c.push_back(mk(0,0,1,'hE1,   0,0,0,      1,'h204, 0,0,0));
        tbl_c.push_back(mk(0,0,1,'hE2,   0,0,0,      1,'h204, 0,0,0));
        tbl_c.push_back(mk(0,0,1,'hF0,   0,0,0,      1,'h204, BYP,'hF0,'h200));
        tbl_c.push_back(mk(0,0,0,0,      1,0,0,      1,'h204, 1,'hF0,'h200));
        tbl_c.push_back(mk(0,0,0,0,      0,0,0,      1,'h204, 0,0,0));
        tbl_c.push_back(mk(0,1,0,0,      0,0,0,      1,'h204, 0,0,0));
        tbl_c.push_back(mk(0,1,0,0,      0,0,0,      1,'h208, 0,0,0));
        tbl_c.push_back(mk(0,1,1,'h11,   0,1,'h300,  0,0,     0,0,0));
        tbl_c.push_back(mk(0,0,1,'h22,   1,0,0,      1,'h300, 0,0,0));
        tbl_c.push_back(mk(0,1,0,0,      0,0,0,      1,'h300, 0,0,0));
        tbl_c.push_back(mk(0,0,1,'hDEAD, 1,0,0,      1,'h304, BYP,'hDEAD,'h300));
        tbl_c.push_back(mk(0,0,0,0,      1,0,0,      1,'h304, 1-BYP,'hDEAD,'h300));
        tbl_c.push_back(mk(0,0,0,0,      0,0,0,      1,'h304, 0,0,0));
        tbl_c.push_back(mk(0,1,0,0,      0,0,0,      1,'h304, 0,0,0));
        tbl_c.push_back(mk(0,0,1,'h44,   0,0,0,      1,'h308, BYP,'h44,'h304));
        tbl_c.push_back(mk(1,1,0,0,      0,0,0,      0,0,     0,0,0));
        tbl_c.push_back(mk(0,0,0,0,      0,0,0,      1,'h100, 0,0,0));

        foreach (tbl_a[i]) step(tbl_a[i]);

        // Steady state: one entry queued, one in flight, push and pop every cycle across many wraps.
        step(mk(0,1,0,0,     0,0,0, 1,'h110, 0,0,0));
        step(mk(0,1,1,'hB0,  0,0,0, 1,'h114, BYP,'hB0,'h110));
        for (int k = 0; k < 20; k++) begin
            prev = (k == 0) ? 32'hB0 : 32'hC0 + 32'(k) - 32'd1;
            step(mk(0,1,1,32'hC0 + 32'(k), 1,0,0, 1,32'h118 + 32'(4*k),
                    1,prev,32'h110 + 32'(4*k)));
        end
        step(mk(0,0,0,0,     1,0,0, 1,'h168, 1,'hD3,'h160));

        foreach (tbl_c[i]) step(tbl_c[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
